// File: rtl/mips32_pkg.sv
// mips32_pkg: opcodes, instruction classes and IR field slices shared by the MIPS32 pipeline stages
package mips32_pkg;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND = 6'b000010, OR = 6'b000011;
    localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, LW = 6'b001000, SW = 6'b001001;
    localparam logic [5:0] ADDI = 6'b001010, SUBI = 6'b001011, SLTI = 6'b001100;
    localparam logic [5:0] BNEQZ = 6'b001101, BEQZ = 6'b001110, HLT = 6'b111111;
    localparam logic [2:0] RR_ALU = 3'd0, RM_ALU = 3'd1, LOAD = 3'd2, STORE = 3'd3, BRANCH = 3'd4, HALT = 3'd5;
    localparam int OP_HI = 31, OP_LO = 26, RS_HI = 25, RS_LO = 21;
    localparam int RT_HI = 20, RT_LO = 16, RD_HI = 15, RD_LO = 11;
    function automatic logic writes_reg(input logic [2:0] t);
        return t == RR_ALU || t == RM_ALU || t == LOAD;
    endfunction
endpackage

// File: rtl/mips32_regfile.sv
// mips32_regfile: 32-entry register bank, one write port, two write-first bypassed read ports, r0 reads 0
module mips32_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG = 32
) (
    input  logic                    clk1,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [$clog2(NREG)-1:0] ra_addr,
    input  logic [$clog2(NREG)-1:0] rb_addr,
    output logic [DATA_W-1:0]       ra_data,
    output logic [DATA_W-1:0]       rb_data
);
    logic [DATA_W-1:0] regs [NREG];
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end
    always_comb begin
        ra_data = ra_addr == '0 ? '0 : (we && waddr == ra_addr) ? wdata : regs[ra_addr];
        rb_data = rb_addr == '0 ? '0 : (we && waddr == rb_addr) ? wdata : regs[rb_addr];
    end
endmodule

// File: rtl/mips32_wb_stage.sv
// mips32_wb_stage: MIPS32 write-back stage with register bank, HALT freeze FSM and retire counter
module mips32_wb_stage
    import mips32_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              mem_wb_valid,
    input  logic [2:0]        mem_wb_type,
    input  logic [31:0]       mem_wb_ir,
    input  logic [DATA_W-1:0] mem_wb_aluout,
    input  logic [DATA_W-1:0] mem_wb_lmd,
    input  logic              taken_branch,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_fwd_valid,
    output logic [4:0]        wb_fwd_addr,
    output logic [DATA_W-1:0] wb_fwd_data,
    output logic              halted,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);
    localparam logic ST_RUN = 1'b0, ST_HALTED = 1'b1;
    logic state, commit, we;
    logic [4:0] dest;
    logic [DATA_W-1:0] wdata;
    always_comb begin
        commit = rst_n & mem_wb_valid & ~taken_branch & (state == ST_RUN);
        dest = mem_wb_type == RR_ALU ? mem_wb_ir[RD_HI:RD_LO] : mem_wb_ir[RT_HI:RT_LO];
        wdata = mem_wb_type == LOAD ? mem_wb_lmd : mem_wb_aluout;
        we = commit & writes_reg(mem_wb_type) & (dest != 5'd0);
    end
    assign wb_fwd_valid = we;
    assign wb_fwd_addr = we ? dest : 5'd0;
    assign wb_fwd_data = we ? wdata : '0;
    assign halted = state == ST_HALTED;
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state <= ST_RUN;
            illegal <= 1'b0;
            retired <= '0;
        end else if (commit) begin
            retired <= retired + 1'b1;
            if (mem_wb_type == HALT) state <= ST_HALTED;
            if (mem_wb_type == 3'd6 || mem_wb_type == 3'd7) begin
                state <= ST_HALTED;
                illegal <= 1'b1;
            end
        end
    end
    mips32_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
        .clk1(clk1),
        .rst_n(rst_n),
        .we(we),
        .waddr(dest),
        .wdata(wdata),
        .ra_addr(rs_addr),
        .rb_addr(rt_addr),
        .ra_data(rs_data),
        .rb_data(rt_data)
    );
endmodule

// File: tb/tb_mips32_wb_stage.sv
// tb_mips32_wb_stage: directed and randomized checks of the WB stage against a behavioural model
module tb_mips32_wb_stage;
    logic clk1 = 1'b0, rst_n = 1'b0, mem_wb_valid = 1'b0, taken_branch = 1'b0;
    logic [2:0] mem_wb_type = 3'd0;
    logic [31:0] mem_wb_ir = '0, mem_wb_aluout = '0, mem_wb_lmd = '0;
    logic [4:0] rs_addr = '0, rt_addr = '0;
    logic [31:0] rs_data, rt_data, wb_fwd_data, retired;
    logic [4:0] wb_fwd_addr;
    logic wb_fwd_valid, halted, illegal;
    int checks = 0, errors = 0;
    logic [31:0] m_regs [32];
    logic m_halt, m_ill, model_ok = 1'b0;
    logic [31:0] m_ret;

    mips32_wb_stage dut (
        .clk1(clk1), .rst_n(rst_n), .mem_wb_valid(mem_wb_valid), .mem_wb_type(mem_wb_type),
        .mem_wb_ir(mem_wb_ir), .mem_wb_aluout(mem_wb_aluout), .mem_wb_lmd(mem_wb_lmd),
        .taken_branch(taken_branch), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .wb_fwd_valid(wb_fwd_valid),
        .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_dest(input logic [2:0] t, input logic [31:0] ir);
        case (t)
            3'd0: return ir[15:11];
            3'd1, 3'd2: return ir[20:16];
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic m_commit();
        return rst_n && mem_wb_valid && !taken_branch && !m_halt;
    endfunction

    function automatic logic m_we();
        return m_commit() && m_dest(mem_wb_type, mem_wb_ir) != 5'd0;
    endfunction

    function automatic logic [31:0] m_wdata();
        return mem_wb_type == 3'd2 ? mem_wb_lmd : mem_wb_aluout;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_we() && m_dest(mem_wb_type, mem_wb_ir) == a) return m_wdata();
        return m_regs[a];
    endfunction

    always @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            m_halt <= 1'b0;
            m_ill <= 1'b0;
            m_ret <= '0;
            model_ok <= 1'b1;
        end else if (m_commit()) begin
            m_ret <= m_ret + 32'd1;
            if (m_we()) m_regs[m_dest(mem_wb_type, mem_wb_ir)] <= m_wdata();
            if (mem_wb_type >= 3'd5) m_halt <= 1'b1;
            if (mem_wb_type >= 3'd6) m_ill <= 1'b1;
        end
    end

    always @(negedge clk1) begin
        if (model_ok) begin
            chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
            chk("m_illegal", {31'd0, illegal}, {31'd0, m_ill});
            chk("m_retired", retired, m_ret);
            chk("m_rs_data", rs_data, m_read(rs_addr));
            chk("m_rt_data", rt_data, m_read(rt_addr));
            chk("m_fwd_valid", {31'd0, wb_fwd_valid}, {31'd0, m_we()});
            chk("m_fwd_addr", {27'd0, wb_fwd_addr}, {27'd0, m_we() ? m_dest(mem_wb_type, mem_wb_ir) : 5'd0});
            chk("m_fwd_data", wb_fwd_data, m_we() ? m_wdata() : 32'd0);
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] rt, input logic [4:0] rd);
        return {11'd0, rt, rd, 11'd0};
    endfunction

    task automatic drive(input logic r, input logic v, input logic [2:0] ty, input logic [31:0] ir,
                         input logic [31:0] alu, input logic [31:0] lmd, input logic tb,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk1);
        #1;
        rst_n = r; mem_wb_valid = v; mem_wb_type = ty; mem_wb_ir = ir;
        mem_wb_aluout = alu; mem_wb_lmd = lmd; taken_branch = tb; rs_addr = ra; rt_addr = rb;
        #3;
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, ra, rb);
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        idle(5'd5, 5'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        chk("reset_retired", retired, 32'd0);
        chk("reset_r5", rs_data, 32'd0);
        drive(1'b1, 1'b1, 3'd0, mk(5'd0, 5'd3), 32'hAB, 32'd0, 1'b0, 5'd3, 5'd0);
        chk("rr_bypass", rs_data, 32'hAB);
        chk("rr_fwd_valid", {31'd0, wb_fwd_valid}, 32'd1);
        chk("rr_fwd_addr", {27'd0, wb_fwd_addr}, 32'd3);
        idle(5'd3, 5'd0);
        chk("rr_r3", rs_data, 32'hAB);
        chk("rr_retired", retired, 32'd1);
        drive(1'b1, 1'b1, 3'd2, mk(5'd7, 5'd0), 32'h5, 32'hDEAD_BEEF, 1'b0, 5'd7, 5'd0);
        chk("load_fwd_data", wb_fwd_data, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 3'd1, mk(5'd0, 5'd0), 32'h55, 32'd0, 1'b0, 5'd0, 5'd7);
        chk("load_r7", rt_data, 32'hDEAD_BEEF);
        chk("rm_r0_read", rs_data, 32'd0);
        chk("rm_r0_fwd_valid", {31'd0, wb_fwd_valid}, 32'd0);
        idle(5'd0, 5'd0);
        chk("rm_r0_retired", retired, 32'd3);
        drive(1'b1, 1'b1, 3'd3, mk(5'd7, 5'd3), 32'h11, 32'h22, 1'b0, 5'd0, 5'd0);
        chk("store_fwd_valid", {31'd0, wb_fwd_valid}, 32'd0);
        drive(1'b1, 1'b1, 3'd4, mk(5'd3, 5'd3), 32'h33, 32'h44, 1'b0, 5'd0, 5'd0);
        chk("branch_fwd_valid", {31'd0, wb_fwd_valid}, 32'd0);
        idle(5'd7, 5'd3);
        chk("st_br_retired", retired, 32'd5);
        chk("st_br_r7", rs_data, 32'hDEAD_BEEF);
        chk("st_br_r3", rt_data, 32'hAB);
        drive(1'b1, 1'b1, 3'd0, mk(5'd0, 5'd4), 32'h77, 32'd0, 1'b1, 5'd4, 5'd0);
        chk("squash_fwd_valid", {31'd0, wb_fwd_valid}, 32'd0);
        drive(1'b1, 1'b1, 3'd5, 32'd0, 32'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        idle(5'd4, 5'd0);
        chk("squash_r4", rs_data, 32'd0);
        chk("squash_retired", retired, 32'd5);
        chk("squash_halted", {31'd0, halted}, 32'd0);
        drive(1'b1, 1'b1, 3'd5, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        drive(1'b1, 1'b1, 3'd0, mk(5'd0, 5'd5), 32'h99, 32'd0, 1'b0, 5'd5, 5'd0);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_retired", retired, 32'd6);
        chk("halt_fwd_valid", {31'd0, wb_fwd_valid}, 32'd0);
        idle(5'd5, 5'd3);
        chk("halt_r5", rs_data, 32'd0);
        chk("halt_r3_live", rt_data, 32'hAB);
        chk("halt_retired_frozen", retired, 32'd6);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 3'd6, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        chk("ill_pre_halted", {31'd0, halted}, 32'd0);
        idle(5'd0, 5'd0);
        chk("ill_halted", {31'd0, halted}, 32'd1);
        chk("ill_illegal", {31'd0, illegal}, 32'd1);
        chk("ill_retired", retired, 32'd1);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 3'd0, mk(5'd0, 5'd9), 32'h1234, 32'd0, 1'b0, 5'd0, 5'd0);
        drive(1'b0, 1'b1, 3'd0, mk(5'd0, 5'd9), 32'h5, 32'd0, 1'b0, 5'd9, 5'd0);
        chk("rst_pre_r9", rs_data, 32'h1234);
        idle(5'd9, 5'd0);
        chk("rst_r9", rs_data, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [2:0] ty;
            r = int'($urandom_range(0, 99));
            ty = r < 98 ? 3'(r % 5) : r == 98 ? 3'd5 : 3'(6 + $urandom_range(0, 1));
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, ty, $urandom,
                  $urandom, $urandom, $urandom_range(0, 7) == 0,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(5'd0, 5'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
